// File: rtl/ex_mem_req_stage.sv
// Execute stage: effective address, alignment check and SRAM-like data request.
// Holds one instruction until the bus accepts it, then hands it on to ME.
`timescale 1ns/1ps
module ex_mem_req_stage #(
  parameter  int XLEN      = 32,
  parameter  int PAYLOAD_W = 64,
  localparam int NB        = XLEN / 8,
  localparam int OW        = $clog2(NB)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_allow,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_mem_en,
  input  logic                 in_mem_wr,
  input  logic                 in_mem_signed,
  input  logic [1:0]           in_mem_size,
  input  logic [XLEN-1:0]      in_base,
  input  logic [XLEN-1:0]      in_offset,
  input  logic [XLEN-1:0]      in_store_data,
  input  logic [XLEN-1:0]      in_alu_result,
  input  logic [4:0]           in_dest,
  input  logic                 in_gr_we,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_allow,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [XLEN-1:0]      out_result,
  output logic                 out_killed,
  output logic                 out_mem_pending,
  output logic                 out_ale,
  output logic [OW+2:0]        out_ld_flags,
  output logic [4:0]           out_dest,
  output logic                 out_gr_we,
  output logic                 data_req,
  output logic                 data_wr,
  output logic [1:0]           data_size,
  output logic [NB-1:0]        data_wstrb,
  output logic [XLEN-1:0]      data_addr,
  output logic [XLEN-1:0]      data_wdata,
  input  logic                 data_addr_ok,
  output logic [4:0]           fwd_dest,
  output logic [XLEN-1:0]      fwd_result,
  output logic                 fwd_is_load
);

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_ISSUED, S_KILL
  } state_t;

  state_t state, state_n;

  logic [PAYLOAD_W-1:0] payload_q;
  logic                 mem_en_q, wr_q, sgn_q;
  logic [1:0]           size_q;
  logic [XLEN-1:0]      result_q, sdata_q;
  logic [OW-1:0]        alo_q;
  logic [4:0]           dest_q;
  logic                 gr_we_q, ale_q, pend_q;

  logic [XLEN-1:0] addr;
  logic [2:0]      amask;
  logic            ale_n;
  logic            valid, acc, ready_go, load, fire;
  state_t          load_st;

  assign addr  = in_base + in_offset;
  assign amask = {in_mem_size == 2'd3, in_mem_size[1], |in_mem_size};
  assign ale_n = in_mem_en && |(addr[2:0] & amask);

  assign valid    = state != S_IDLE;
  assign acc      = state == S_WAIT && data_addr_ok;
  assign ready_go = state == S_ISSUED || state == S_KILL || acc;
  // A flush wins over a live entry; only accepted requests survive as KILL.
  assign out_valid = ready_go && !(flush && state == S_ISSUED);
  assign fire      = out_valid && out_allow;
  assign in_allow  = !valid || (ready_go && out_allow);
  assign load      = in_valid && in_allow && !flush;
  assign load_st   = (in_mem_en && !ale_n) ? S_WAIT : S_ISSUED;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (load) state_n = load_st;
      S_WAIT:
        if (flush)
          state_n = (data_addr_ok && !out_allow) ? S_KILL : S_IDLE;
        else if (data_addr_ok)
          state_n = !out_allow ? S_ISSUED
                  : load ? load_st : S_IDLE;
      S_ISSUED:
        if (flush)
          state_n = pend_q ? S_KILL : S_IDLE;
        else if (out_allow)
          state_n = load ? load_st : S_IDLE;
      S_KILL:
        if (out_allow) state_n = load ? load_st : S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      pend_q   <= 1'b0;
      ale_q    <= 1'b0;
      mem_en_q <= 1'b0;
      gr_we_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (load) begin
        pend_q   <= 1'b0;
        ale_q    <= ale_n;
        mem_en_q <= in_mem_en;
        gr_we_q  <= in_gr_we && !ale_n;
      end else if (acc) begin
        pend_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      payload_q <= in_payload;
      wr_q      <= in_mem_wr;
      sgn_q     <= in_mem_signed;
      size_q    <= in_mem_size;
      result_q  <= in_mem_en ? addr : in_alu_result;
      alo_q     <= addr[OW-1:0];
      sdata_q   <= in_store_data;
      dest_q    <= in_dest;
    end
  end

  logic [OW-1:0] lane_mask, lane;
  logic [NB-1:0] strb_base;

  always_comb begin
    lane_mask = '1;
    strb_base = '1;
    case (size_q)
      2'd0: begin lane_mask = '0;     strb_base = NB'(1);  end
      2'd1: begin lane_mask = OW'(1); strb_base = NB'(3);  end
      2'd2: begin lane_mask = OW'(3); strb_base = NB'(15); end
      default: ;
    endcase
  end

  // Store data is replicated so every byte lane carries the right byte.
  always_comb begin
    lane       = '0;
    data_wdata = '0;
    for (int i = 0; i < NB; i++) begin
      lane = OW'(i) & lane_mask;
      data_wdata[8*i +: 8] = sdata_q[{lane, 3'b000} +: 8];
    end
  end

  assign data_wstrb = wr_q ? (strb_base << alo_q) : '0;
  assign data_req   = state == S_WAIT;
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = result_q;

  assign out_payload     = payload_q;
  assign out_result      = result_q;
  assign out_killed      = state == S_KILL || (acc && flush);
  assign out_mem_pending = (pend_q && valid) || acc;
  assign out_ale         = ale_q;
  assign out_ld_flags    = {sgn_q, size_q, alo_q};
  assign out_dest        = dest_q;
  assign out_gr_we       = gr_we_q;

  assign fwd_dest    = (valid && gr_we_q && state != S_KILL) ? dest_q : 5'd0;
  assign fwd_result  = result_q;
  assign fwd_is_load = valid && mem_en_q && !wr_q;

endmodule

// File: tb/tb_ex_mem_req_stage.sv
// Bench for ex_mem_req_stage: transaction model feeding scoreboard queues,
// random and directed stimulus, plus a few XLEN=64 alignment cases.
`timescale 1ns/1ps
module tb_ex_mem_req_stage;
  localparam int PW = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        in_valid, in_allow;
  logic [PW-1:0] in_payload;
  logic        in_mem_en, in_mem_wr, in_mem_signed;
  logic [1:0]  in_mem_size;
  logic [31:0] in_base, in_offset, in_store_data, in_alu_result;
  logic [4:0]  in_dest;
  logic        in_gr_we, flush, out_valid, out_allow;
  logic [PW-1:0] out_payload;
  logic [31:0] out_result;
  logic        out_killed, out_mem_pending, out_ale;
  logic [4:0]  out_ld_flags, out_dest;
  logic        out_gr_we, data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_result;
  logic        fwd_is_load;

  ex_mem_req_stage #(.XLEN(32), .PAYLOAD_W(PW)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_allow(in_allow), .in_payload(in_payload),
    .in_mem_en(in_mem_en), .in_mem_wr(in_mem_wr),
    .in_mem_signed(in_mem_signed), .in_mem_size(in_mem_size),
    .in_base(in_base), .in_offset(in_offset),
    .in_store_data(in_store_data), .in_alu_result(in_alu_result),
    .in_dest(in_dest), .in_gr_we(in_gr_we), .flush(flush),
    .out_valid(out_valid), .out_allow(out_allow),
    .out_payload(out_payload), .out_result(out_result),
    .out_killed(out_killed), .out_mem_pending(out_mem_pending),
    .out_ale(out_ale), .out_ld_flags(out_ld_flags),
    .out_dest(out_dest), .out_gr_we(out_gr_we),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .fwd_dest(fwd_dest), .fwd_result(fwd_result),
    .fwd_is_load(fwd_is_load)
  );

  logic        w_in_valid, w_in_allow;
  logic [PW-1:0] w_in_payload;
  logic        w_in_mem_en, w_in_mem_wr, w_in_mem_signed;
  logic [1:0]  w_in_mem_size;
  logic [63:0] w_in_base, w_in_offset, w_in_store_data, w_in_alu_result;
  logic [4:0]  w_in_dest;
  logic        w_in_gr_we, w_flush, w_out_valid, w_out_allow;
  logic [PW-1:0] w_out_payload;
  logic [63:0] w_out_result;
  logic        w_out_killed, w_out_mem_pending, w_out_ale;
  logic [5:0]  w_out_ld_flags;
  logic [4:0]  w_out_dest;
  logic        w_out_gr_we, w_data_req, w_data_wr;
  logic [1:0]  w_data_size;
  logic [7:0]  w_data_wstrb;
  logic [63:0] w_data_addr, w_data_wdata;
  logic        w_data_addr_ok;
  logic [4:0]  w_fwd_dest;
  logic [63:0] w_fwd_result;
  logic        w_fwd_is_load;

  ex_mem_req_stage #(.XLEN(64), .PAYLOAD_W(PW)) u_dut64 (
    .clk(clk), .reset(reset),
    .in_valid(w_in_valid), .in_allow(w_in_allow),
    .in_payload(w_in_payload),
    .in_mem_en(w_in_mem_en), .in_mem_wr(w_in_mem_wr),
    .in_mem_signed(w_in_mem_signed), .in_mem_size(w_in_mem_size),
    .in_base(w_in_base), .in_offset(w_in_offset),
    .in_store_data(w_in_store_data), .in_alu_result(w_in_alu_result),
    .in_dest(w_in_dest), .in_gr_we(w_in_gr_we), .flush(w_flush),
    .out_valid(w_out_valid), .out_allow(w_out_allow),
    .out_payload(w_out_payload), .out_result(w_out_result),
    .out_killed(w_out_killed), .out_mem_pending(w_out_mem_pending),
    .out_ale(w_out_ale), .out_ld_flags(w_out_ld_flags),
    .out_dest(w_out_dest), .out_gr_we(w_out_gr_we),
    .data_req(w_data_req), .data_wr(w_data_wr),
    .data_size(w_data_size), .data_wstrb(w_data_wstrb),
    .data_addr(w_data_addr), .data_wdata(w_data_wdata),
    .data_addr_ok(w_data_addr_ok),
    .fwd_dest(w_fwd_dest), .fwd_result(w_fwd_result),
    .fwd_is_load(w_fwd_is_load)
  );

  typedef struct {
    logic [63:0] payload;
    logic [31:0] result;
    logic        ale;
    logic [4:0]  dest;
    logic        gr_we;
    logic [4:0]  flags;
    logic        killed;
    logic        pending;
    logic        mem_en;
    logic        wr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } req_t;

  exp_t exp_q[$];
  req_t req_q[$];
  exp_t cur, m_e;
  req_t m_r;

  bit occ, acc, nreq, kil, drop_exp, drop_req, chk_en;
  bit e_req, e_valid, e_allow, e_fl;
  logic [4:0] e_fwd;
  int errors = 0;
  int checks = 0;
  int reqcnt = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Expected entry and bus request from the instruction on the inputs.
  function automatic void build(output exp_t e, output req_t r);
    logic [31:0] a;
    int nb, lo;
    a  = in_base + in_offset;
    nb = 1 << in_mem_size;
    lo = int'(a % 4);
    e.payload = in_payload;
    e.ale     = in_mem_en && (a % nb != 0);
    e.result  = in_mem_en ? a : in_alu_result;
    e.dest    = in_dest;
    e.gr_we   = in_gr_we && !e.ale;
    e.flags   = {in_mem_signed, in_mem_size, a[1:0]};
    e.killed  = 1'b0;
    e.pending = 1'b0;
    e.mem_en  = in_mem_en;
    e.wr      = in_mem_wr;
    r.addr  = a;
    r.size  = in_mem_size;
    r.wr    = in_mem_wr;
    r.strb  = '0;
    r.wdata = '0;
    for (int b = 0; b < 4; b++) begin
      if (in_mem_wr && b >= lo && b < lo + nb) r.strb[b] = 1'b1;
      r.wdata[8*b +: 8] = in_store_data[8*(b % nb) +: 8];
    end
  endfunction

  // One cycle of the model; inputs are already applied.
  task automatic tick();
    bit req_now, acc_now, rdy, pres, ld, fire;
    exp_t e;
    req_t r;
    if (drop_exp) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      drop_exp = 0;
    end
    if (drop_req) begin
      if (req_q.size() > 0) void'(req_q.pop_front());
      drop_req = 0;
    end
    req_now = occ && nreq && !acc;
    acc_now = acc || (req_now && data_addr_ok);
    rdy     = occ && (!nreq || acc_now);
    pres    = rdy && (kil || !flush || (req_now && data_addr_ok));
    e_allow = !occ || (rdy && out_allow);
    ld      = in_valid && e_allow && !flush;
    fire    = pres && out_allow;
    e_req   = req_now;
    e_valid = pres;
    e_fl    = occ && cur.mem_en && !cur.wr;
    e_fwd   = (occ && cur.gr_we && !kil) ? cur.dest : 5'd0;
    if (pres && exp_q.size() > 0) begin
      exp_q[0].killed  = kil || flush;
      exp_q[0].pending = acc_now;
    end
    if (occ && flush && !fire) begin
      if (acc_now) begin
        kil = 1; acc = 1;
      end else begin
        occ = 0; drop_exp = 1; drop_req = req_now;
      end
    end else if (fire) begin
      occ = 0;
    end else if (req_now && data_addr_ok) begin
      acc = 1;
    end
    if (ld) begin
      build(e, r);
      exp_q.push_back(e);
      if (e.mem_en && !e.ale) req_q.push_back(r);
      cur = e; occ = 1; acc = 0; kil = 0;
      nreq = e.mem_en && !e.ale;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input bit me, wr, sg, input logic [1:0] sz,
                         input logic [31:0] base, off, sd, alu,
                         input logic [4:0] d, input bit gw);
    in_payload    = {$urandom, $urandom};
    in_mem_en     = me;
    in_mem_wr     = wr;
    in_mem_signed = sg;
    in_mem_size   = sz;
    in_base       = base;
    in_offset     = off;
    in_store_data = sd;
    in_alu_result = alu;
    in_dest       = d;
    in_gr_we      = gw;
  endtask

  task automatic cyc(input bit iv, fl, ok, oa);
    in_valid     = iv;
    flush        = fl;
    data_addr_ok = ok;
    out_allow    = oa;
    tick();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_allow", in_allow, e_allow);
      chk("out_valid", out_valid, e_valid);
      chk("data_req", data_req, e_req);
      chk("fwd_dest", fwd_dest, e_fwd);
      chk("fwd_is_load", fwd_is_load, e_fl);
      if (data_req) begin
        reqcnt++;
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_unexpected got=%0h exp=none", data_addr);
        end else begin
          m_r = req_q[0];
          chk("req_addr", data_addr, m_r.addr);
          chk("req_size", data_size, m_r.size);
          chk("req_wr", data_wr, m_r.wr);
          chk("req_wstrb", data_wstrb, m_r.strb);
          chk("req_wdata", data_wdata, m_r.wdata);
          if (data_addr_ok) void'(req_q.pop_front());
        end
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_unexpected got=%0h exp=none", out_result);
        end else begin
          m_e = exp_q[0];
          chk("out_payload", out_payload, m_e.payload);
          chk("out_result", out_result, m_e.result);
          chk("fwd_result", fwd_result, m_e.result);
          chk("out_ale", out_ale, m_e.ale);
          chk("out_dest", out_dest, m_e.dest);
          chk("out_gr_we", out_gr_we, m_e.gr_we);
          chk("out_ld_flags", out_ld_flags, m_e.flags);
          chk("out_killed", out_killed, m_e.killed);
          chk("out_mem_pending", out_mem_pending, m_e.pending);
          if (out_allow) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int r0;
    logic [31:0] b;
    reset = 1'b1;
    chk_en = 0;
    e_allow = 1;
    set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 0; flush = 0; data_addr_ok = 0; out_allow = 0;
    w_in_valid = 0; w_in_payload = '0; w_in_mem_en = 0; w_in_mem_wr = 0;
    w_in_mem_signed = 0; w_in_mem_size = 0; w_in_base = '0;
    w_in_offset = '0; w_in_store_data = '0; w_in_alu_result = '0;
    w_in_dest = 0; w_in_gr_we = 0; w_flush = 0; w_out_allow = 0;
    w_data_addr_ok = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_req", data_req, 0);
    chk("rst_killed", out_killed, 0);
    chk("rst_pending", out_mem_pending, 0);
    chk("rst_ale", out_ale, 0);
    chk("rst_fwd_is_load", fwd_is_load, 0);
    chk("rst_fwd_dest", fwd_dest, 0);
    chk("rst64_out_valid", w_out_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1;

    set_ins(0, 0, 0, 2, 0, 0, 0, 32'h1234, 5'd5, 1);
    cyc(1, 0, 0, 1);
    chk("alu_out_valid", out_valid, 1);
    chk("alu_result", out_result, 32'h1234);
    chk("alu_fwd_dest", fwd_dest, 5'd5);
    cyc(0, 0, 0, 1);

    set_ins(1, 1, 0, 0, 32'h1000, 3, 32'hAB, 0, 0, 0);
    r0 = reqcnt;
    cyc(1, 0, 0, 1);
    chk("stb_wstrb", data_wstrb, 4'b1000);
    chk("stb_wdata", data_wdata, 32'hABABABAB);
    repeat (3) cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    chk("stb_req_cycles", reqcnt - r0, 4);
    chk("stb_req_done", data_req, 0);

    set_ins(1, 0, 1, 1, 32'h1000, 1, 0, 0, 5'd7, 1);
    cyc(1, 0, 0, 1);
    chk("ldh_ale", out_ale, 1);
    chk("ldh_fwd_dest", fwd_dest, 0);
    chk("ldh_no_req", data_req, 0);
    chk("ldh_valid", out_valid, 1);
    cyc(0, 0, 0, 1);

    set_ins(1, 0, 0, 2, 32'h3000, 4, 0, 0, 5'd9, 1);
    cyc(1, 0, 0, 1);
    cyc(0, 1, 0, 1);
    chk("flw_req_drop", data_req, 0);
    chk("flw_allow", in_allow, 1);
    chk("flw_no_valid", out_valid, 0);

    set_ins(1, 1, 0, 2, 32'h4000, 8, 32'h11223344, 0, 0, 0);
    cyc(1, 0, 0, 1);
    set_ins(0, 0, 0, 0, 0, 0, 0, 32'h55, 5'd3, 1);
    cyc(1, 1, 1, 1);
    chk("flok_no_load", out_valid, 0);
    chk("flok_no_req", data_req, 0);

    set_ins(1, 0, 1, 1, 32'h5002, 0, 0, 0, 5'd4, 1);
    cyc(1, 0, 0, 1);
    cyc(0, 1, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      b = $urandom;
      if ($urandom % 4 != 0) b[1:0] = 2'b00;
      set_ins(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
              2'($urandom % 3), b, 32'($urandom % 16), $urandom,
              $urandom, 5'($urandom % 32), 1'($urandom % 2));
      cyc($urandom % 4 != 0, $urandom % 12 == 0,
          1'($urandom % 2), $urandom % 4 != 0);
    end
    repeat (6) cyc(0, 0, 1, 1);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("req_q_drained", req_q.size(), 0);
    chk_en = 0;

    w_in_mem_en = 1; w_in_mem_wr = 0; w_in_mem_signed = 1;
    w_in_mem_size = 2'd3; w_in_base = 64'h2000; w_in_offset = 64'h8;
    w_in_gr_we = 1; w_in_dest = 5'd6;
    w_in_valid = 1; w_out_allow = 1; w_data_addr_ok = 0;
    @(posedge clk);
    #1;
    w_in_valid = 0;
    chk("ldd_req", w_data_req, 1);
    chk("ldd_size", w_data_size, 3);
    chk("ldd_flags", w_out_ld_flags, 6'b111000);
    chk("ldd_addr", w_data_addr, 64'h2008);
    chk("ldd_ale", w_out_ale, 0);
    chk("ldd_wait", w_out_valid, 0);
    w_data_addr_ok = 1;
    #1;
    chk("ldd_valid", w_out_valid, 1);
    chk("ldd_pending", w_out_mem_pending, 1);
    @(posedge clk);
    #1;
    w_data_addr_ok = 0;
    chk("ldd_req_done", w_data_req, 0);
    w_in_mem_wr = 1; w_in_offset = 64'h4; w_in_valid = 1;
    @(posedge clk);
    #1;
    w_in_valid = 0;
    chk("std_ale", w_out_ale, 1);
    chk("std_no_req", w_data_req, 0);
    chk("std_valid", w_out_valid, 1);
    chk("std_gr_we", w_out_gr_we, 0);
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
